// File: rtl/cdb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cdb_pkg
// Description : Common data bus shared definitions: lane count, payload
//               widths, lane index type and a saturating counter helper.
// Revision    : 1.0 - initial release
// ============================================================================
package cdb_pkg;

   localparam int CDB_LANES  = 4;
   localparam int CDB_DATA_W = 64;
   localparam int CDB_TAG_W  = 6;
   localparam int CDB_LANE_W = (CDB_LANES > 1) ? $clog2(CDB_LANES) : 1;

   typedef logic [CDB_LANE_W-1:0] cdb_lane_t;

   // Add without wrapping: clamps at all-ones.
   function automatic logic [31:0] cdb_sat_add32(input logic [31:0] a, input logic [31:0] b);
      logic [32:0] sum;
      sum = {1'b0, a} + {1'b0, b};
      return sum[32] ? 32'hFFFF_FFFF : sum[31:0];
   endfunction

endpackage
`default_nettype wire

// File: rtl/cdb_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : cdb_arbiter_if
// Description : Request/grant bundle between the completion buffers and the
//               CDB arbiter, including per-lane ownership and debug state.
// Revision    : 1.0 - initial release
// ============================================================================
interface cdb_arbiter_if
   import cdb_pkg::*;
#(
   parameter int NREQ  = 8,
   parameter int LANES = CDB_LANES,
   parameter int IW    = $clog2(NREQ),
   parameter int LW    = (LANES > 1) ? $clog2(LANES) : 1
);
   logic                  kill;
   logic [NREQ-1:0]       bus_request;
   logic [NREQ-1:0]       bus_grant;
   logic [NREQ*LW-1:0]    grant_lane;
   logic [LANES-1:0]      lane_valid;
   logic [LANES*IW-1:0]   lane_owner;
   logic [IW-1:0]         rr_ptr_o;
   logic [31:0]           grant_count;

   // Requesting side: completion buffers and flush control.
   modport master (
      output kill, bus_request,
      input  bus_grant, grant_lane, lane_valid, lane_owner, rr_ptr_o, grant_count
   );

   // Responding side: the arbiter.
   modport slave (
      input  kill, bus_request,
      output bus_grant, grant_lane, lane_valid, lane_owner, rr_ptr_o, grant_count
   );
endinterface
`default_nettype wire

// File: rtl/cdb_arbiter_rr_multi_pick.sv
`default_nettype none
// ============================================================================
// Module      : rr_multi_pick
// Description : Combinational round-robin picker granting up to LANES set
//               request bits, scanning from ptr and assigning lanes in scan
//               order. Also produces the follow-on pointer and grant count.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_multi_pick
   import cdb_pkg::*;
#(
   parameter int NREQ  = 8,
   parameter int LANES = CDB_LANES,
   parameter int IW    = $clog2(NREQ),
   parameter int LW    = (LANES > 1) ? $clog2(LANES) : 1
)(
   input  logic [NREQ-1:0]    req,
   input  logic [IW-1:0]      ptr,
   output logic [NREQ-1:0]    grant,
   output logic [NREQ*LW-1:0] lane,
   output logic [IW-1:0]      next_ptr,
   output logic [31:0]        num_grants
);

   localparam logic [IW-1:0] c_last_idx = IW'(NREQ - 1);

   int            w_cnt;
   int            w_sum;
   logic [IW-1:0] w_idx;
   logic [IW-1:0] w_last;

   // Walk the rotated request vector, granting the first LANES set bits.
   always_comb begin
      grant      = '0;
      lane       = '0;
      w_cnt      = 0;
      w_sum      = 0;
      w_idx      = '0;
      w_last     = ptr;
      for (int s = 0; s < NREQ; s++) begin
         w_sum = int'(ptr) + s;
         if (w_sum >= NREQ) begin
            w_sum = w_sum - NREQ;
         end
         w_idx = IW'(w_sum);
         if (req[w_idx] && (w_cnt < LANES)) begin
            grant[w_idx]            = 1'b1;
            lane[w_idx*LW +: LW]    = LW'(w_cnt);
            w_cnt                   = w_cnt + 1;
            w_last                  = w_idx;
         end
      end
      // Next scan starts just past the last granted requester.
      next_ptr = ptr;
      if (w_cnt != 0) begin
         next_ptr = (w_last == c_last_idx) ? '0 : w_last + 1'b1;
      end
      num_grants = 32'(w_cnt);
   end

endmodule
`default_nettype wire

// File: rtl/cdb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : cdb_arbiter
// Description : Central CDB lane arbiter. Samples requests one cycle ahead,
//               registers multi-lane round-robin grants, exposes a per-lane
//               ownership view, and keeps a saturating grant counter.
// Revision    : 1.0 - initial release
// ============================================================================
module cdb_arbiter
   import cdb_pkg::*;
#(
   parameter int NREQ  = 8,
   parameter int LANES = CDB_LANES,
   parameter int IW    = $clog2(NREQ),
   parameter int LW    = (LANES > 1) ? $clog2(LANES) : 1
)(
   input  logic         clk,
   input  logic         rst,
   cdb_arbiter_if.slave bus
);

   logic [NREQ-1:0]     w_req;
   logic [NREQ-1:0]     w_grant;
   logic [NREQ*LW-1:0]  w_lane;
   logic [IW-1:0]       w_next_ptr;
   logic [31:0]         w_num_grants;
   logic [LANES-1:0]    w_lane_valid;
   logic [LANES*IW-1:0] w_lane_owner;

   logic [NREQ-1:0]     r_grant;
   logic [NREQ*LW-1:0]  r_lane;
   logic [LANES-1:0]    r_lane_valid;
   logic [LANES*IW-1:0] r_lane_owner;
   logic [IW-1:0]       r_ptr;
   logic [31:0]         r_grant_count;

   // A flush drops this cycle's requests, so nothing is granted and the
   // pointer and counter hold through the normal no-grant path.
   assign w_req = bus.kill ? '0 : bus.bus_request;

   rr_multi_pick #(
      .NREQ  (NREQ),
      .LANES (LANES),
      .IW    (IW),
      .LW    (LW)
   ) u_pick (
      .req        (w_req),
      .ptr        (r_ptr),
      .grant      (w_grant),
      .lane       (w_lane),
      .next_ptr   (w_next_ptr),
      .num_grants (w_num_grants)
   );

   // Invert the requester->lane map into a lane->requester view.
   always_comb begin
      w_lane_valid = '0;
      w_lane_owner = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (w_grant[i]) begin
            w_lane_valid[w_lane[i*LW +: LW]]         = 1'b1;
            w_lane_owner[w_lane[i*LW +: LW]*IW +: IW] = IW'(i);
         end
      end
   end

   // Register grants for the bus-use cycle; advance pointer and counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_grant       <= '0;
         r_lane        <= '0;
         r_lane_valid  <= '0;
         r_lane_owner  <= '0;
         r_ptr         <= '0;
         r_grant_count <= '0;
      end else begin
         r_grant       <= w_grant;
         r_lane        <= w_lane;
         r_lane_valid  <= w_lane_valid;
         r_lane_owner  <= w_lane_owner;
         r_ptr         <= w_next_ptr;
         r_grant_count <= cdb_sat_add32(r_grant_count, w_num_grants);
      end
   end

   assign bus.bus_grant   = r_grant;
   assign bus.grant_lane  = r_lane;
   assign bus.lane_valid  = r_lane_valid;
   assign bus.lane_owner  = r_lane_owner;
   assign bus.rr_ptr_o    = r_ptr;
   assign bus.grant_count = r_grant_count;

endmodule
`default_nettype wire

// File: tb/tb_cdb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_cdb_arbiter
// Description : Self-checking bench for cdb_arbiter (NREQ=8, LANES=4) using
//               a table of hand-derived vectors plus corner-case sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cdb_arbiter;

   typedef struct {
      logic        kill;
      logic [7:0]  req;
      logic [7:0]  grant;
      logic [15:0] lane;
      logic [3:0]  lv;
      logic [11:0] owner;
      logic [2:0]  ptr;
      logic [31:0] count;
   } vec_t;

   logic clk;
   logic rst;
   int   checks;
   int   errors;
   vec_t tbl[8];
   vec_t exp_q[$];

   cdb_arbiter_if #(.NREQ(8), .LANES(4)) bus ();

   cdb_arbiter #(.NREQ(8), .LANES(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic check_all(input vec_t e, input string tag);
      cmp({tag, ".grant"}, 32'(bus.bus_grant),  32'(e.grant));
      cmp({tag, ".lane"},  32'(bus.grant_lane), 32'(e.lane));
      cmp({tag, ".lv"},    32'(bus.lane_valid), 32'(e.lv));
      cmp({tag, ".owner"}, 32'(bus.lane_owner), 32'(e.owner));
      cmp({tag, ".ptr"},   32'(bus.rr_ptr_o),   32'(e.ptr));
      cmp({tag, ".count"}, bus.grant_count,     e.count);
   endtask

   // Drive one cycle of stimulus, queue its expectation, compare after the edge.
   task automatic step(input vec_t v, input string tag);
      vec_t e;
      @(negedge clk);
      bus.kill        = v.kill;
      bus.bus_request = v.req;
      exp_q.push_back(v);
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) begin
         checks++;
         errors++;
         $display("FAIL %s: scoreboard empty", tag);
      end else begin
         e = exp_q.pop_front();
         check_all(e, tag);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst             = 1'b1;
      bus.kill        = 1'b0;
      bus.bus_request = '0;
      @(posedge clk);
      #1;
      @(negedge clk);
      rst = 1'b0;
   endtask

   function automatic vec_t mk(input logic k, input logic [7:0] r, input logic [7:0] g,
                               input logic [15:0] l, input logic [3:0] lv,
                               input logic [11:0] o, input logic [2:0] p,
                               input logic [31:0] c);
      vec_t v;
      v.kill = k; v.req = r; v.grant = g; v.lane = l;
      v.lv = lv; v.owner = o; v.ptr = p; v.count = c;
      return v;
   endfunction

   initial begin
      vec_t zero_v;
      checks = 0;
      errors = 0;
      rst             = 1'b1;
      bus.kill        = 1'b0;
      bus.bus_request = '0;

      // Sequential vectors starting from the reset state (ptr=0, count=0).
      tbl[0] = mk(1'b0, 8'h04, 8'h04, 16'h0000, 4'b0001, 12'h002, 3'd3, 32'd1);
      tbl[1] = mk(1'b0, 8'h00, 8'h00, 16'h0000, 4'b0000, 12'h000, 3'd3, 32'd1);
      tbl[2] = mk(1'b0, 8'hFF, 8'h78, 16'h3900, 4'b1111, 12'hD63, 3'd7, 32'd5);
      tbl[3] = mk(1'b0, 8'hFF, 8'h87, 16'h0039, 4'b1111, 12'h447, 3'd3, 32'd9);
      tbl[4] = mk(1'b1, 8'h0F, 8'h00, 16'h0000, 4'b0000, 12'h000, 3'd3, 32'd9);
      tbl[5] = mk(1'b0, 8'h0F, 8'h0F, 16'h0039, 4'b1111, 12'h443, 3'd3, 32'd13);
      tbl[6] = mk(1'b0, 8'hC3, 8'hC3, 16'h400E, 4'b1111, 12'h23E, 3'd2, 32'd17);
      tbl[7] = mk(1'b0, 8'h21, 8'h21, 16'h0001, 4'b0011, 12'h005, 3'd1, 32'd19);

      repeat (2) @(posedge clk);
      #1;
      zero_v = mk(1'b0, 8'h00, 8'h00, 16'h0000, 4'b0000, 12'h000, 3'd0, 32'd0);
      check_all(zero_v, "reset");
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < 8; i++) begin
         step(tbl[i], $sformatf("vec%0d", i));
      end

      // Oversubscription: all eight requesting from ptr=0.
      do_reset();
      step(mk(1'b0, 8'hFF, 8'h0F, 16'h00E4, 4'b1111, 12'h688, 3'd4, 32'd4),  "over1");
      step(mk(1'b0, 8'hFF, 8'hF0, 16'hE400, 4'b1111, 12'hFAC, 3'd0, 32'd8),  "over2");
      step(mk(1'b0, 8'hFF, 8'h0F, 16'h00E4, 4'b1111, 12'h688, 3'd4, 32'd12), "over3");

      // Wrap-around: move ptr to 6, then scan 6,7,0,1.
      do_reset();
      step(mk(1'b0, 8'h20, 8'h20, 16'h0000, 4'b0001, 12'h005, 3'd6, 32'd1), "wrap_a");
      step(mk(1'b0, 8'hC3, 8'hC3, 16'h400E, 4'b1111, 12'h23E, 3'd2, 32'd5), "wrap_b");

      // Kill: grants already on the bus are untouched, next cycle is empty.
      do_reset();
      step(mk(1'b0, 8'h0F, 8'h0F, 16'h00E4, 4'b1111, 12'h688, 3'd4, 32'd4), "kill_a");
      @(negedge clk);
      bus.kill        = 1'b1;
      bus.bus_request = 8'h0F;
      #1;
      cmp("kill_visible.grant", 32'(bus.bus_grant), 32'h0F);
      @(posedge clk);
      #1;
      check_all(mk(1'b1, 8'h0F, 8'h00, 16'h0000, 4'b0000, 12'h000, 3'd4, 32'd4), "kill_b");
      step(mk(1'b0, 8'h0F, 8'h0F, 16'h00E4, 4'b1111, 12'h688, 3'd4, 32'd8), "kill_c");

      // Reset mid-traffic with requests still asserted.
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         bus.kill        = 1'b0;
         bus.bus_request = 8'hFF;
      end
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      check_all(zero_v, "midrst");
      @(negedge clk);
      rst             = 1'b0;
      bus.bus_request = '0;

      // Saturation: preload the counter near the top.
      @(negedge clk);
      force dut.r_grant_count = 32'hFFFF_FFFE;
      #1;
      release dut.r_grant_count;
      step(mk(1'b0, 8'h0F, 8'h0F, 16'h00E4, 4'b1111, 12'h688, 3'd4, 32'hFFFF_FFFF), "sat_a");
      step(mk(1'b0, 8'hFF, 8'hF0, 16'hE400, 4'b1111, 12'hFAC, 3'd0, 32'hFFFF_FFFF), "sat_b");

      @(negedge clk);
      bus.bus_request = '0;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
